// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU sequencing controller and its display scanner:
// opcode encodings, FSM state type, digit-index codes and anode patterns.
package alu_ctrl_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOTB = 3'd2;
  localparam logic [2:0] OP_SHL  = 3'd3;
  localparam logic [2:0] OP_ADD  = 3'd4;
  localparam logic [2:0] OP_SUB  = 3'd5;
  localparam logic [2:0] OP_MUL  = 3'd6;
  localparam logic [2:0] OP_XOR  = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  localparam logic [1:0] DIG_RESULT = 2'd0;
  localparam logic [1:0] DIG_OP     = 2'd1;
  localparam logic [1:0] DIG_B      = 2'd2;
  localparam logic [1:0] DIG_A      = 2'd3;

  // Active-low anode enables, one digit lit at a time
  localparam logic [3:0] AN_RESULT = 4'b1110;
  localparam logic [3:0] AN_OP     = 4'b1101;
  localparam logic [3:0] AN_B      = 4'b1011;
  localparam logic [3:0] AN_A      = 4'b0111;

endpackage

// File: rtl/alu_display_ctrl_disp_scan.sv
// Four-digit display scanner: a free-running prescaler advances the digit
// index every REFRESH_DIV cycles; anode enable and digit nibble are
// registered together so the segment decoder never sees a mismatched pair.
module disp_scan
  import alu_ctrl_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] result_q,
  input  logic [2:0] op,
  input  logic [3:0] b,
  input  logic [3:0] a,
  output logic [3:0] digit,
  output logic [3:0] an
);

  localparam int PW = $clog2(REFRESH_DIV);

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic          wrap;
  logic [3:0]    sel_digit;
  logic [3:0]    sel_an;

  assign wrap = (presc == PW'(REFRESH_DIV - 1));

  // Prescaler and digit index advance; index steps once per prescaler wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= DIG_RESULT;
    end else begin
      if (wrap) begin
        presc <= '0;
        idx   <= idx + 2'd1;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  // Select the nibble and anode pattern for the current index
  always_comb begin
    sel_digit = result_q;
    sel_an    = AN_RESULT;
    case (idx)
      DIG_RESULT: begin sel_digit = result_q;     sel_an = AN_RESULT; end
      DIG_OP:     begin sel_digit = {1'b0, op};   sel_an = AN_OP;     end
      DIG_B:      begin sel_digit = b;            sel_an = AN_B;      end
      DIG_A:      begin sel_digit = a;            sel_an = AN_A;      end
      default:    begin sel_digit = result_q;     sel_an = AN_RESULT; end
    endcase
  end

  // Register anode and digit together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= 4'h0;
      an    <= AN_RESULT;
    end else begin
      digit <= sel_digit;
      an    <= sel_an;
    end
  end

endmodule

// File: rtl/alu_display_ctrl.sv
// Sequencing controller for an external 4-bit ALU plus display scan.
// One request is accepted in IDLE, operands are held on the ALU for
// SETTLE_CYCLES cycles, then the result is captured with a one-cycle done.
// Optional macro ALU_CTRL_STATUS_EN adds the ovf status output.
module alu_display_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int REFRESH_DIV   = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] a_in,
  input  logic [3:0] b_in,
  input  logic [2:0] op_in,
  input  logic [3:0] alu_result,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  output logic       busy,
  output logic       done,
  output logic [3:0] result_q,
  output logic [3:0] digit,
  output logic [3:0] an
`ifdef ALU_CTRL_STATUS_EN
  ,
  output logic       ovf
`endif
);

  state_t     state, state_nx;
  logic [3:0] cnt;
  logic       accept;
  logic       capture;

`ifdef ALU_CTRL_STATUS_EN
  // Overflow/borrow status derived from the held operands, not the ALU output
  function automatic logic calc_ovf(input logic [3:0] a, input logic [3:0] b,
                                    input logic [2:0] op);
    logic [4:0] sum;
    logic [7:0] prod;
    logic [7:0] shl;
    logic       r;
    sum  = {1'b0, a} + {1'b0, b};
    prod = {4'h0, a} * {4'h0, b};
    shl  = {4'h0, a} << b[1:0];
    r    = 1'b0;
    case (op)
      OP_ADD:  r = sum[4];
      OP_SUB:  r = (a < b);
      OP_MUL:  r = |prod[7:4];
      OP_SHL:  r = (b >= 4'd4) ? (|a) : (|shl[7:4]);
      default: r = 1'b0;
    endcase
    return r;
  endfunction
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state decode: accept a request in IDLE, capture when settle expires
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    capture  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt == 4'd0) begin
          capture  = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_EXEC);

  // Settle counter: loaded on accept, counts down while executing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           cnt <= 4'd0;
    else if (accept)                      cnt <= 4'(SETTLE_CYCLES - 1);
    else if (busy && (cnt != 4'd0))       cnt <= cnt - 4'd1;
  end

  // Operand/opcode registers driving the ALU, held until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a  <= 4'h0;
      alu_b  <= 4'h0;
      alu_op <= OP_AND;
    end else if (accept) begin
      alu_a  <= a_in;
      alu_b  <= b_in;
      alu_op <= op_in;
    end
  end

  // Result capture and one-cycle completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= 4'h0;
      done     <= 1'b0;
`ifdef ALU_CTRL_STATUS_EN
      ovf      <= 1'b0;
`endif
    end else begin
      done <= capture;
      if (capture) begin
        result_q <= alu_result;
`ifdef ALU_CTRL_STATUS_EN
        ovf      <= calc_ovf(alu_a, alu_b, alu_op);
`endif
      end
    end
  end

  disp_scan #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .result_q (result_q),
    .op       (alu_op),
    .b        (alu_b),
    .a        (alu_a),
    .digit    (digit),
    .an       (an)
  );

endmodule

// File: tb/tb_alu_display_ctrl.sv
// Testbench for alu_display_ctrl: two instances (settle 1 and settle 3, both
// with a short refresh divider), each fed by a behavioural ALU.
module tb_alu_display_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a_in, b_in;
  logic [2:0] op_in;
  logic       start1, start3;

  logic [3:0] alu_result1, alu_a1, alu_b1, result_q1, digit1, an1;
  logic [2:0] alu_op1;
  logic       busy1, done1;
  logic [3:0] alu_result3, alu_a3, alu_b3, result_q3, digit3, an3;
  logic [2:0] alu_op3;
  logic       busy3, done3;
`ifdef ALU_CTRL_STATUS_EN
  logic       ovf1, ovf3;
`endif

  int checks   = 0;
  int failures = 0;
  logic [4:0] q1[$];
  logic [4:0] q3[$];

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] op);
    logic [3:0] r;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = ~b;
      3'd3: r = a << b;
      3'd4: r = a + b;
      3'd5: r = a - b;
      3'd6: r = a * b;
      default: r = a ^ b;
    endcase
    return r;
  endfunction

  function automatic logic ovf_fn(input logic [3:0] a, input logic [3:0] b,
                                  input logic [2:0] op);
    int ai = int'(a);
    int bi = int'(b);
    case (op)
      3'd3: return (ai << bi) > 15;
      3'd4: return (ai + bi) > 15;
      3'd5: return ai < bi;
      3'd6: return (ai * bi) > 15;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [4:0] expect_fn(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] op);
    return {ovf_fn(a, b, op), alu_fn(a, b, op)};
  endfunction

  assign alu_result1 = alu_fn(alu_a1, alu_b1, alu_op1);
  assign alu_result3 = alu_fn(alu_a3, alu_b3, alu_op3);

  alu_display_ctrl #(.SETTLE_CYCLES(1), .REFRESH_DIV(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a_in), .b_in(b_in),
    .op_in(op_in), .alu_result(alu_result1), .alu_a(alu_a1), .alu_b(alu_b1),
    .alu_op(alu_op1), .busy(busy1), .done(done1), .result_q(result_q1),
    .digit(digit1), .an(an1)
`ifdef ALU_CTRL_STATUS_EN
    , .ovf(ovf1)
`endif
  );

  alu_display_ctrl #(.SETTLE_CYCLES(3), .REFRESH_DIV(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a_in(a_in), .b_in(b_in),
    .op_in(op_in), .alu_result(alu_result3), .alu_a(alu_a3), .alu_b(alu_b3),
    .alu_op(alu_op3), .busy(busy3), .done(done3), .result_q(result_q3),
    .digit(digit3), .an(an3)
`ifdef ALU_CTRL_STATUS_EN
    , .ovf(ovf3)
`endif
  );

  // Pulse start1 for one cycle (called at a negedge); returns at the sample
  // point just after the accepting edge.
  task automatic issue1(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    a_in = a; b_in = b; op_in = op; start1 = 1'b1;
    q1.push_back(expect_fn(a, b, op));
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic issue3(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    a_in = a; b_in = b; op_in = op; start3 = 1'b1;
    q3.push_back(expect_fn(a, b, op));
    @(negedge clk);
    start3 = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0;
    a_in = 4'h0; b_in = 4'h0; op_in = 3'd0;
    #1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || result_q1 !== 4'h0) begin
      failures++;
      $display("FAIL reset_ctrl busy=%b done=%b result_q=%h required 0/0/0", busy1, done1, result_q1);
    end
    checks++;
    if (alu_a1 !== 4'h0 || alu_b1 !== 4'h0 || alu_op1 !== 3'd0) begin
      failures++;
      $display("FAIL reset_operands a=%h b=%h op=%h required 0/0/0", alu_a1, alu_b1, alu_op1);
    end
    checks++;
    if (an1 !== 4'b1110 || digit1 !== 4'h0) begin
      failures++;
      $display("FAIL reset_display an=%b digit=%h required 1110/0", an1, digit1);
    end
`ifdef ALU_CTRL_STATUS_EN
    checks++;
    if (ovf1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_ovf got=%b required 0", ovf1);
    end
`endif
  endtask

  task automatic test_ops;
    logic [10:0] tbl [0:8];
    logic [4:0]  exp;
    tbl = '{{4'h5, 4'h3, 3'd4}, {4'h3, 4'h5, 3'd5}, {4'h4, 4'h5, 3'd6},
            {4'h9, 4'h2, 3'd1}, {4'hA, 4'hC, 3'd0}, {4'h1, 4'h2, 3'd3},
            {4'h3, 4'h4, 3'd3}, {4'h7, 4'h9, 3'd7}, {4'h0, 4'hB, 3'd2}};
    for (int i = 0; i < 9; i++) begin
      issue1(tbl[i][10:7], tbl[i][6:3], tbl[i][2:0]);
      checks++;
      if (busy1 !== 1'b1 || done1 !== 1'b0) begin
        failures++;
        $display("FAIL op%0d_busy busy=%b done=%b required busy=1 done=0", i, busy1, done1);
      end
      @(negedge clk);
      checks++;
      if (done1 !== 1'b1 || busy1 !== 1'b0) begin
        failures++;
        $display("FAIL op%0d_done done=%b busy=%b required done=1 busy=0", i, done1, busy1);
        q1.delete();
      end else begin
        exp = q1.pop_front();
        checks++;
        if (result_q1 !== exp[3:0]) begin
          failures++;
          $display("FAIL op%0d_result got=%h required %h", i, result_q1, exp[3:0]);
        end
`ifdef ALU_CTRL_STATUS_EN
        checks++;
        if (ovf1 !== exp[4]) begin
          failures++;
          $display("FAIL op%0d_ovf got=%b required %b", i, ovf1, exp[4]);
        end
`endif
      end
      @(negedge clk);
      checks++;
      if (done1 !== 1'b0) begin
        failures++;
        $display("FAIL op%0d_done_pulse done=%b required 0", i, done1);
      end
    end
  endtask

  task automatic test_display;
    logic [3:0] pat [0:3];
    logic [3:0] dig [0:3];
    logic [3:0] prev;
    logic [4:0] exp;
    bit         found;
    pat = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    dig = '{4'hB, 4'h1, 4'h2, 4'h9};
    issue1(4'h9, 4'h2, 3'd1);
    @(negedge clk);
    checks++;
    if (done1 !== 1'b1) begin
      failures++;
      $display("FAIL disp_done done=%b required 1", done1);
      q1.delete();
    end else begin
      exp = q1.pop_front();
      checks++;
      if (result_q1 !== exp[3:0]) begin
        failures++;
        $display("FAIL disp_result got=%h required %h", result_q1, exp[3:0]);
      end
    end
    prev  = an1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (prev == 4'b0111 && an1 == 4'b1110) found = 1'b1;
      else prev = an1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL disp_sync no 0111->1110 transition within 40 cycles, an=%b", an1);
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (k > 0) @(negedge clk);
        checks++;
        if (an1 !== pat[k/4] || digit1 !== dig[k/4]) begin
          failures++;
          $display("FAIL disp_scan cycle%0d an=%b digit=%h required %b/%h",
                   k, an1, digit1, pat[k/4], dig[k/4]);
        end
      end
      @(negedge clk);
      checks++;
      if (an1 !== 4'b1110 || digit1 !== 4'hB) begin
        failures++;
        $display("FAIL disp_wrap an=%b digit=%h required 1110/b", an1, digit1);
      end
    end
  endtask

  task automatic test_ignore;
    int         nb = 0;
    int         nd = 0;
    logic [3:0] rq = 4'h0;
    logic [4:0] exp;
    issue3(4'h1, 4'h2, 3'd4);
    for (int k = 0; k < 10; k++) begin
      if (busy3 === 1'b1) nb++;
      if (done3 === 1'b1) begin nd++; rq = result_q3; end
      if (k == 1) begin
        a_in = 4'hF; b_in = 4'hF; op_in = 3'd6; start3 = 1'b1;
      end else begin
        start3 = 1'b0;
      end
      @(negedge clk);
    end
    exp = q3.pop_front();
    checks++;
    if (nb != 3) begin
      failures++;
      $display("FAIL ignore_busy_len got=%0d required 3", nb);
    end
    checks++;
    if (nd != 1) begin
      failures++;
      $display("FAIL ignore_done_count got=%0d required 1", nd);
    end
    checks++;
    if (rq !== exp[3:0]) begin
      failures++;
      $display("FAIL ignore_result got=%h required %h", rq, exp[3:0]);
    end
    checks++;
    if (alu_a3 !== 4'h1 || alu_b3 !== 4'h2 || alu_op3 !== 3'd4) begin
      failures++;
      $display("FAIL ignore_operands a=%h b=%h op=%h required 1/2/4", alu_a3, alu_b3, alu_op3);
    end
  endtask

  task automatic test_back_to_back;
    int         nd = 0;
    int         t [0:3];
    logic [4:0] exp;
    a_in = 4'h6; b_in = 4'h7; op_in = 3'd4; start1 = 1'b1;
    repeat (3) q1.push_back(expect_fn(4'h6, 4'h7, 3'd4));
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 5) start1 = 1'b0;
      if (done1 === 1'b1) begin
        if (nd < 4) t[nd] = k;
        nd++;
        if (q1.size() > 0) begin
          exp = q1.pop_front();
          checks++;
          if (result_q1 !== exp[3:0]) begin
            failures++;
            $display("FAIL b2b_result%0d got=%h required %h", nd, result_q1, exp[3:0]);
          end
        end
      end
    end
    q1.delete();
    checks++;
    if (nd != 3) begin
      failures++;
      $display("FAIL b2b_done_count got=%0d required 3", nd);
    end else begin
      checks++;
      if (t[1] - t[0] != 2 || t[2] - t[1] != 2) begin
        failures++;
        $display("FAIL b2b_spacing got=%0d,%0d required 2,2", t[1] - t[0], t[2] - t[1]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int nd = 0;
    issue3(4'hC, 4'h3, 3'd6);
    checks++;
    if (busy3 !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_busy_before got=%b required 1", busy3);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy3 !== 1'b0 || done3 !== 1'b0 || result_q3 !== 4'h0) begin
      failures++;
      $display("FAIL rstmid_ctrl busy=%b done=%b result_q=%h required 0/0/0", busy3, done3, result_q3);
    end
    checks++;
    if (alu_a3 !== 4'h0 || alu_b3 !== 4'h0 || alu_op3 !== 3'd0 ||
        an3 !== 4'b1110 || digit3 !== 4'h0) begin
      failures++;
      $display("FAIL rstmid_outputs a=%h b=%h op=%h an=%b digit=%h required 0/0/0/1110/0",
               alu_a3, alu_b3, alu_op3, an3, digit3);
    end
    @(negedge clk);
    rst_n = 1'b1;
    q3.delete();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done3 === 1'b1) nd++;
    end
    checks++;
    if (nd != 0 || busy3 !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_no_done dones=%0d busy=%b required 0/0", nd, busy3);
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_display();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
